// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
// Records register-writeback (commit) events from the pipeline into a
// first-word-fall-through trace FIFO. Each entry holds the capture cycle, the
// retiring PC, the destination register and the writeback data. Capture runs
// over a bounded cycle window and stops when the program halts (the IF-stage
// PC stops changing) or when the window ends. The FIFO keeps draining after
// capture has stopped.
// Optional feature macro: TRACE_DISPLAY_EN enables simulation-only event logging.
module pipeline_trace_buffer #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CYC_W       = 16,
    parameter int MAX_CYCLES  = 31,
    parameter int HALT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     wb_valid_i,
    input  logic [XLEN-1:0]          wb_pc_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [CYC_W-1:0]         rd_cycle_o,
    output logic [XLEN-1:0]          rd_pc_o,
    output logic [4:0]               rd_reg_o,
    output logic [XLEN-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CYC_W-1:0]         cycle_o,
    output logic                     overflow_o,
    output logic                     halted_o,
    output logic                     done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int HC_W  = $clog2(HALT_CYCLES + 1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } haltState_t;

    // FIFO storage, one array per entry field
    logic [CYC_W-1:0] r_memCycle [DEPTH];
    logic [XLEN-1:0]  r_memPc    [DEPTH];
    logic [4:0]       r_memReg   [DEPTH];
    logic [XLEN-1:0]  r_memData  [DEPTH];

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [CYC_W-1:0] r_cycle;

    haltState_t       r_state;
    logic [HC_W-1:0]  r_runCnt;
    logic [XLEN-1:0]  r_lastPc;
    logic             r_lastValid;
    logic             r_halted;
    logic             r_done;

    logic w_notEmpty;
    logic w_full;
    logic w_want;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_pcMatch;
    logic w_haltSet;
    logic w_cycleEnd;

    // Handshake decode: a pop needs a real head entry, and a push into a full
    // FIFO is only allowed when the head leaves on the same edge
    always_comb begin
        w_notEmpty = (r_count != '0);
        w_full     = (r_count == CNT_W'(DEPTH));
        w_want     = wb_valid_i && (wb_rd_i != 5'd0) && !r_done;
        w_pop      = w_notEmpty && rd_ready_i;
        w_push     = w_want && (!w_full || w_pop);
        w_drop     = w_want && w_full && !w_pop;
        w_pcMatch  = r_lastValid && (pc_i == r_lastPc);
        w_haltSet  = (r_state == ST_RUN) && w_pcMatch &&
                     (r_runCnt == HC_W'(HALT_CYCLES - 1));
        w_cycleEnd = (r_cycle == CYC_W'(MAX_CYCLES - 1)) ||
                     (r_cycle == CYC_W'(MAX_CYCLES));
    end

    // Write the captured event into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memCycle[r_wrPtr] <= r_cycle;
            r_memPc[r_wrPtr]    <= wb_pc_i;
            r_memReg[r_wrPtr]   <= wb_rd_i;
            r_memData[r_wrPtr]  <= wb_data_i;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Cycle counter that saturates at the last cycle of the capture window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (r_cycle != CYC_W'(MAX_CYCLES)) begin
            r_cycle <= r_cycle + CYC_W'(1);
        end
    end

    // Halt detector: counts consecutive cycles with an unchanged IF PC and
    // latches halted/done; done also latches when the window ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_runCnt    <= '0;
            r_lastPc    <= '0;
            r_lastValid <= 1'b0;
            r_halted    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_lastPc    <= pc_i;
            r_lastValid <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (w_pcMatch) begin
                        if (w_haltSet) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_runCnt <= r_runCnt + HC_W'(1);
                        end
                    end else begin
                        r_runCnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
            if (w_haltSet || w_cycleEnd) begin
                r_done <= 1'b1;
            end
        end
    end

    // Head of the FIFO falls through to the read port; zeros when empty
    always_comb begin
        rd_valid_o = w_notEmpty;
        rd_cycle_o = '0;
        rd_pc_o    = '0;
        rd_reg_o   = '0;
        rd_data_o  = '0;
        if (w_notEmpty) begin
            rd_cycle_o = r_memCycle[r_rdPtr];
            rd_pc_o    = r_memPc[r_rdPtr];
            rd_reg_o   = r_memReg[r_rdPtr];
            rd_data_o  = r_memData[r_rdPtr];
        end
    end

    assign count_o    = r_count;
    assign cycle_o    = r_cycle;
    assign overflow_o = r_overflow;
    assign halted_o   = r_halted;
    assign done_o     = r_done;

`ifdef TRACE_DISPLAY_EN
    logic w_doneRise;
    logic w_overflowRise;

    // Edge-detect the sticky flags so each is logged once
    always_comb begin
        w_doneRise     = (w_haltSet || w_cycleEnd) && !r_done;
        w_overflowRise = w_drop && !r_overflow;
    end

    // Simulation-only event log; has no effect on any port
    always @(posedge clk) begin
        if (!rst) begin
            if (w_push) begin
                $display("cyc=%d pc=%h x%0d=%h", r_cycle, wb_pc_i, wb_rd_i, wb_data_i);
            end
            if (w_haltSet) begin
                $display("trace: halted_o rises at cyc=%0d", r_cycle);
            end
            if (w_doneRise) begin
                $display("trace: done_o rises at cyc=%0d", r_cycle);
            end
            if (w_overflowRise) begin
                $display("trace: overflow_o rises at cyc=%0d", r_cycle);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer
// Table-driven vectors for reset and the basic capture path, hand sequences
// for overflow, halt, window end and mid-run reset, then randomized traffic
// compared against a queue-based reference model of the trace buffer.
module tb_pipeline_trace_buffer;

    localparam int XLEN        = 32;
    localparam int DEPTH       = 16;
    localparam int CYC_W       = 16;
    localparam int MAX_CYCLES  = 31;
    localparam int HALT_CYCLES = 4;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   pc_i;
    logic              wb_valid_i;
    logic [XLEN-1:0]   wb_pc_i;
    logic [4:0]        wb_rd_i;
    logic [XLEN-1:0]   wb_data_i;
    logic              rd_ready_i;
    logic              rd_valid_o;
    logic [CYC_W-1:0]  rd_cycle_o;
    logic [XLEN-1:0]   rd_pc_o;
    logic [4:0]        rd_reg_o;
    logic [XLEN-1:0]   rd_data_o;
    logic [4:0]        count_o;
    logic [CYC_W-1:0]  cycle_o;
    logic              overflow_o;
    logic              halted_o;
    logic              done_o;

    pipeline_trace_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CYC_W(CYC_W),
        .MAX_CYCLES(MAX_CYCLES), .HALT_CYCLES(HALT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .wb_valid_i(wb_valid_i),
        .wb_pc_i(wb_pc_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_cycle_o(rd_cycle_o),
        .rd_pc_o(rd_pc_o), .rd_reg_o(rd_reg_o), .rd_data_o(rd_data_o),
        .count_o(count_o), .cycle_o(cycle_o), .overflow_o(overflow_o),
        .halted_o(halted_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        wbValid;
        logic [31:0] wbPc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rdReady;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        expValid;
        int          expCount;
        int          expCycle;
        int          expHeadCyc;
        logic [31:0] expPc;
        logic [4:0]  expReg;
        logic [31:0] expData;
        logic        expOvf;
        logic        expHalt;
        logic        expDone;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int assertions = 0;
    int failures   = 0;

    ent_t        mq[$];
    int          mCycle;
    logic        mOvf;
    logic        mHalt;
    logic        mDone;
    logic [31:0] mLastPc;
    logic        mHaveLast;
    int          mRunLen;

    vec_t vecs[10];

    function automatic stim_t mkStim(logic r, logic [31:0] pc, logic v, logic [31:0] wpc,
                                     logic [4:0] rd, logic [31:0] data, logic rdy);
        stim_t s;
        s.rst = r; s.pc = pc; s.wbValid = v; s.wbPc = wpc;
        s.rd = rd; s.data = data; s.rdReady = rdy;
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t s, logic v, int cnt, int cyc, int hcyc,
                                   logic [31:0] hpc, logic [4:0] hreg, logic [31:0] hdata,
                                   logic ovf, logic hlt, logic dn);
        vec_t t;
        t.s = s; t.expValid = v; t.expCount = cnt; t.expCycle = cyc;
        t.expHeadCyc = hcyc; t.expPc = hpc; t.expReg = hreg; t.expData = hdata;
        t.expOvf = ovf; t.expHalt = hlt; t.expDone = dn;
        return t;
    endfunction

    // Reference model: one clock edge of the trace buffer described by its rules
    task automatic modelStep(input stim_t s);
        bit   popNow;
        bit   capture;
        ent_t e;
        int   nextCycle;
        if (s.rst) begin
            mq.delete();
            mCycle = 0; mOvf = 0; mHalt = 0; mDone = 0;
            mLastPc = 0; mHaveLast = 0; mRunLen = 0;
        end else begin
            popNow  = (mq.size() > 0) && s.rdReady;
            capture = s.wbValid && (s.rd != 0) && !mDone;
            if (capture && mq.size() == DEPTH && !popNow) begin
                mOvf = 1;
                capture = 0;
            end
            if (popNow) void'(mq.pop_front());
            if (capture) begin
                e.cyc = mCycle; e.pc = s.wbPc; e.rd = s.rd; e.data = s.data;
                mq.push_back(e);
            end
            if (mHaveLast && s.pc == mLastPc) mRunLen++;
            else mRunLen = 0;
            if (mRunLen >= HALT_CYCLES) mHalt = 1;
            nextCycle = (mCycle < MAX_CYCLES) ? mCycle + 1 : MAX_CYCLES;
            if (mHalt || nextCycle == MAX_CYCLES) mDone = 1;
            mCycle    = nextCycle;
            mLastPc   = s.pc;
            mHaveLast = 1;
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge
    task automatic applyStimulus(input stim_t s);
        rst        = s.rst;
        pc_i       = s.pc;
        wb_valid_i = s.wbValid;
        wb_pc_i    = s.wbPc;
        wb_rd_i    = s.rd;
        wb_data_i  = s.data;
        rd_ready_i = s.rdReady;
        @(posedge clk);
        modelStep(s);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the reference model
    task automatic checkOutput(input string tag);
        bit   hv;
        ent_t h;
        hv = (mq.size() > 0);
        h.cyc = 0; h.pc = 0; h.rd = 0; h.data = 0;
        if (hv) h = mq[0];
        checkVal({tag, ".rd_valid"}, 64'(rd_valid_o), 64'(hv));
        checkVal({tag, ".count"},    64'(count_o),    64'(mq.size()));
        checkVal({tag, ".cycle"},    64'(cycle_o),    64'(mCycle));
        checkVal({tag, ".rd_cycle"}, 64'(rd_cycle_o), 64'(h.cyc));
        checkVal({tag, ".rd_pc"},    64'(rd_pc_o),    64'(h.pc));
        checkVal({tag, ".rd_reg"},   64'(rd_reg_o),   64'(h.rd));
        checkVal({tag, ".rd_data"},  64'(rd_data_o),  64'(h.data));
        checkVal({tag, ".overflow"}, 64'(overflow_o), 64'(mOvf));
        checkVal({tag, ".halted"},   64'(halted_o),   64'(mHalt));
        checkVal({tag, ".done"},     64'(done_o),     64'(mDone));
    endtask

    task automatic idle(input logic [31:0] pc, input logic rdy);
        applyStimulus(mkStim(1'b0, pc, 1'b0, 32'h0, 5'd0, 32'h0, rdy));
    endtask

    initial begin
        stim_t s;
        logic [31:0] pcNow;
        int          pcCnt;

        // Reset, idle, a capture at cycle 3, an x0 write, pop+push, empty push+pop
        vecs[0] = mkVec(mkStim(1, 32'h100, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1] = mkVec(mkStim(1, 32'h104, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2] = mkVec(mkStim(0, 32'h108, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3] = mkVec(mkStim(0, 32'h10C, 0, 0, 0, 0, 0), 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mkVec(mkStim(0, 32'h110, 0, 0, 0, 0, 0), 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mkVec(mkStim(0, 32'h114, 1, 32'h8, 5, 32'h10, 0),
                        1, 1, 4, 3, 32'h8, 5, 32'h10, 0, 0, 0);
        vecs[6] = mkVec(mkStim(0, 32'h118, 1, 32'h20, 0, 32'hDEAD, 0),
                        1, 1, 5, 3, 32'h8, 5, 32'h10, 0, 0, 0);
        vecs[7] = mkVec(mkStim(0, 32'h11C, 1, 32'hC, 7, 32'h22, 1),
                        1, 1, 6, 5, 32'hC, 7, 32'h22, 0, 0, 0);
        vecs[8] = mkVec(mkStim(0, 32'h120, 0, 0, 0, 0, 1), 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        vecs[9] = mkVec(mkStim(0, 32'h124, 1, 32'h10, 3, 32'h33, 1),
                        1, 1, 8, 7, 32'h10, 3, 32'h33, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].s);
            checkVal($sformatf("vec%0d.rd_valid", i), 64'(rd_valid_o), 64'(vecs[i].expValid));
            checkVal($sformatf("vec%0d.count", i),    64'(count_o),    64'(vecs[i].expCount));
            checkVal($sformatf("vec%0d.cycle", i),    64'(cycle_o),    64'(vecs[i].expCycle));
            checkVal($sformatf("vec%0d.rd_cycle", i), 64'(rd_cycle_o), 64'(vecs[i].expHeadCyc));
            checkVal($sformatf("vec%0d.rd_pc", i),    64'(rd_pc_o),    64'(vecs[i].expPc));
            checkVal($sformatf("vec%0d.rd_reg", i),   64'(rd_reg_o),   64'(vecs[i].expReg));
            checkVal($sformatf("vec%0d.rd_data", i),  64'(rd_data_o),  64'(vecs[i].expData));
            checkVal($sformatf("vec%0d.overflow", i), 64'(overflow_o), 64'(vecs[i].expOvf));
            checkVal($sformatf("vec%0d.halted", i),   64'(halted_o),   64'(vecs[i].expHalt));
            checkVal($sformatf("vec%0d.done", i),     64'(done_o),     64'(vecs[i].expDone));
        end

        // Window end: cycle saturates at 31, done rises, capture is suppressed
        for (int i = 0; i < 25; i++) begin
            idle(32'h200 + 32'(4 * i), 1'b0);
            checkOutput($sformatf("win%0d", i));
        end
        checkVal("win.cycle_at_max", 64'(cycle_o), 64'(MAX_CYCLES));
        checkVal("win.done", 64'(done_o), 64'd1);
        applyStimulus(mkStim(0, 32'h300, 1, 32'h44, 6, 32'h66, 0));
        checkVal("win.cycle_holds", 64'(cycle_o), 64'(MAX_CYCLES));
        checkVal("win.no_capture_after_done", 64'(count_o), 64'd1);
        idle(32'h304, 1'b1);
        checkVal("win.drain_after_done", 64'(rd_valid_o), 64'd0);
        checkOutput("win.end");

        // Overflow: 17 pushes into 16 entries, then push+pop while full
        applyStimulus(mkStim(1, 32'h0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 17; i++) begin
            applyStimulus(mkStim(0, 32'h400 + 32'(4 * i), 1, 32'h1000 + 32'(i),
                                 5'((i % 31) + 1), 32'(i * 3), 0));
            checkOutput($sformatf("ovf%0d", i));
        end
        checkVal("ovf.count_full", 64'(count_o), 64'(DEPTH));
        checkVal("ovf.flag", 64'(overflow_o), 64'd1);
        checkVal("ovf.head_first", 64'(rd_pc_o), 64'h1000);
        applyStimulus(mkStim(0, 32'h500, 1, 32'h2000, 5'd9, 32'h99, 1));
        checkVal("ovf.pushpop_count", 64'(count_o), 64'(DEPTH));
        checkVal("ovf.pushpop_flag", 64'(overflow_o), 64'd1);
        checkVal("ovf.pushpop_head", 64'(rd_pc_o), 64'h1001);
        checkOutput("ovf.pushpop");
        for (int i = 0; i < 10; i++) begin
            idle(32'h600 + 32'(4 * i), 1'b1);
            checkOutput($sformatf("pop%0d", i));
        end
        checkVal("rstmid.pre_count", 64'(count_o), 64'd6);

        // Reset mid-operation discards entries and clears sticky flags
        applyStimulus(mkStim(1, 32'h700, 1, 32'h77, 5'd4, 32'h44, 0));
        checkVal("rstmid.count", 64'(count_o), 64'd0);
        checkVal("rstmid.rd_valid", 64'(rd_valid_o), 64'd0);
        checkVal("rstmid.overflow", 64'(overflow_o), 64'd0);
        checkVal("rstmid.cycle", 64'(cycle_o), 64'd0);

        // Halt: three entries queued, then PC held at 0x40 for five cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkStim(0, 32'h10 + 32'(4 * i), 1, 32'h3000 + 32'(i),
                                 5'(i + 1), 32'(i), 0));
        end
        for (int i = 0; i < 5; i++) begin
            idle(32'h40, 1'b0);
            checkOutput($sformatf("halt%0d", i));
            if (i == 3) checkVal("halt.not_yet", 64'(halted_o), 64'd0);
        end
        checkVal("halt.halted", 64'(halted_o), 64'd1);
        checkVal("halt.done", 64'(done_o), 64'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(mkStim(0, 32'h40, 1, 32'h4000, 5'd9, 32'h9, 0));
        end
        checkVal("halt.capture_ignored", 64'(count_o), 64'd3);
        for (int i = 0; i < 4; i++) begin
            idle(32'h40, 1'b1);
            checkOutput($sformatf("haltdrain%0d", i));
        end
        checkVal("halt.drained", 64'(count_o), 64'd0);
        checkVal("halt.sticky", 64'(halted_o), 64'd1);

        // Randomized traffic against the reference model
        pcNow = 32'h80;
        pcCnt = 0;
        applyStimulus(mkStim(1, 32'h0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                pcCnt++;
                pcNow = 32'h80 + 32'(4 * (pcCnt % 7));
            end
            s = mkStim(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, pcNow,
                       1'($urandom_range(0, 3) != 0), $urandom(),
                       5'($urandom_range(0, 31)), $urandom(),
                       1'($urandom_range(0, 2) == 0));
            applyStimulus(s);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
